// File: rtl/des_iter_core.sv
// Iterative DES encrypt/decrypt core. It runs RPC Feistel rounds per clock,
// so one block takes 16/RPC clocks. Decryption walks the key schedule
// backwards, which avoids storing the sixteen subkeys.
//
// Handshake (both ports): a transfer happens on a rising clk_in edge where
// valid && ready. A producer holds valid until that transfer. ready never
// depends on the valid of the same port. data_out_valid depends only on the
// state register.
module des_iter_core #(
  parameter int RPC = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [63:0] data_in,
  input  logic [63:0] key_in,
  input  logic        decrypt_in,
  input  logic        data_in_valid,
  output logic        data_in_ready,
  output logic [31:0] left_data_out,
  output logic [31:0] right_data_out,
  output logic        data_out_valid,
  input  logic        data_out_ready
);

  localparam int LAT_CYC = 16 / RPC;
  // Round-counter value at the start of the cycle that completes round 16.
  localparam logic [4:0] LAST_CNT = 5'(RPC * (LAT_CYC - 1));

  if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16)) begin : g_bad_rpc
    $fatal(1, "des_iter_core: RPC must be 1, 2, 4, 8 or 16");
  end

  // FIPS 46-3 tables. Entries are 1-based bit numbers counted from the MSB.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  // Each S-box is 64 nibbles, indexed by row*16+col, with entry 0 in the top nibble.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] perm_ip(input logic [63:0] d);
    logic [63:0] o;
    o = '0;
    for (int k = 0; k < 64; k++) o[63 - k] = d[64 - IP_T[k]];
    return o;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] d);
    logic [63:0] o;
    o = '0;
    for (int k = 0; k < 64; k++) o[63 - k] = d[64 - FP_T[k]];
    return o;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] d);
    logic [55:0] o;
    o = '0;
    for (int k = 0; k < 56; k++) o[55 - k] = d[64 - PC1_T[k]];
    return o;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] d);
    logic [47:0] o;
    o = '0;
    for (int k = 0; k < 48; k++) o[47 - k] = d[56 - PC2_T[k]];
    return o;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] subkey);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] o;
    logic [5:0]  b;
    logic [5:0]  idx;
    x = '0;
    for (int k = 0; k < 48; k++) x[47 - k] = r[32 - E_T[k]];
    x = x ^ subkey;
    s = '0;
    for (int n = 0; n < 8; n++) begin
      b   = x[47 - 6 * n -: 6];
      idx = {b[5], b[0], b[4:1]};
      s[31 - 4 * n -: 4] = SBOX[n][255 - 4 * int'(idx) -: 4];
    end
    o = '0;
    for (int k = 0; k < 32; k++) o[31 - k] = s[32 - P_T[k]];
    return o;
  endfunction

  // rnd is 0-based. An encrypt round rotates left before use. A decrypt
  // round rotates right after use, which is the same as a right rotate
  // before the next round. So decrypt round 1 uses the unshifted C0/D0,
  // which equals C16/D16.
  function automatic logic [1:0] shift_amt(input logic dec, input logic [4:0] rnd);
    logic one;
    one = (rnd == 5'd0) || (rnd == 5'd1) || (rnd == 5'd8) || (rnd == 5'd15);
    if (dec && rnd == 5'd0) return 2'd0;
    return one ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic left, input logic [1:0] n);
    logic [27:0] o;
    case ({left, n})
      3'b101:  o = {x[26:0], x[27]};
      3'b110:  o = {x[25:0], x[27:26]};
      3'b001:  o = {x[0], x[27:1]};
      3'b010:  o = {x[1:0], x[27:2]};
      default: o = x;
    endcase
    return o;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q;
  state_t      state_nx;
  logic [4:0]  round_q;
  logic        decrypt_q;
  logic [31:0] l_q, r_q;
  logic [27:0] c_q, d_q;
  logic        in_fire;

  logic [31:0] l_v, r_v, f_v, t_v;
  logic [27:0] c_v, d_v;
  logic [4:0]  rnd_v;
  logic [1:0]  sh_v;
  logic [63:0] result;

  assign in_fire = data_in_valid && data_in_ready;

  // State register and round counter. Reset overrides any handshake on the same edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      round_q <= '0;
    end else begin
      state_q <= state_nx;
      if (in_fire)
        round_q <= '0;
      else if (state_q == S_RUN)
        round_q <= round_q + 5'(RPC);
    end
  end

  // Next state: the retire and load of the next block can share one edge.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE:  if (in_fire) state_nx = S_RUN;
      S_RUN:   if (round_q == LAST_CNT) state_nx = S_DONE;
      S_DONE:  if (data_out_ready) state_nx = in_fire ? S_RUN : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Handshake outputs and result. They depend only on registered state and data_out_ready.
  always_comb begin
    data_in_ready  = (state_q == S_IDLE) || (state_q == S_DONE && data_out_ready);
    data_out_valid = (state_q == S_DONE);
    result         = perm_fp({r_q, l_q});
    left_data_out  = result[63:32];
    right_data_out = result[31:0];
  end

  // Unrolled chain of RPC rounds that starts from the registered L/R/C/D values.
  always_comb begin
    l_v   = l_q;
    r_v   = r_q;
    c_v   = c_q;
    d_v   = d_q;
    f_v   = '0;
    t_v   = '0;
    rnd_v = '0;
    sh_v  = '0;
    for (int j = 0; j < RPC; j++) begin
      rnd_v = round_q + 5'(j);
      sh_v  = shift_amt(decrypt_q, rnd_v);
      c_v   = rot28(c_v, !decrypt_q, sh_v);
      d_v   = rot28(d_v, !decrypt_q, sh_v);
      f_v   = feistel(r_v, perm_pc2({c_v, d_v}));
      t_v   = l_v ^ f_v;
      l_v   = r_v;
      r_v   = t_v;
    end
  end

  // Block and key registers: load on handshake, advance while running, hold otherwise.
  always_ff @(posedge clk_in) begin
    if (in_fire) begin
      {l_q, r_q} <= perm_ip(data_in);
      {c_q, d_q} <= perm_pc1(key_in);
      decrypt_q  <= decrypt_in;
    end else if (state_q == S_RUN) begin
      l_q <= l_v;
      r_q <= r_v;
      c_q <= c_v;
      d_q <= d_v;
    end
  end

endmodule
